// File: rtl/u_pc_ctrl.sv
// u_pc_ctrl: fetch-PC sequencer with BRU redirect/flush; PC_CTRL_PERF_EN adds a saturating redirect counter
module u_pc_ctrl #(
  parameter int PC_WIDTH = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_pulse,
  input  logic [PC_WIDTH-1:0] start_pc,
  input  logic                stall,
  input  logic                bru_output_vld,
  input  logic                bru_flush,
  input  logic [PC_WIDTH-1:0] bru_redir_pc,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                pc_vld,
  output logic                front_flush,
  output logic                misalign_err,
  output logic                core_busy,
  output logic [31:0]         redirect_cnt
);
  typedef enum logic [1:0] {IDLE, RUN, FLUSH, HALT} state_t;
  state_t state, state_n;
  logic [PC_WIDTH-1:0] pc_n;
  logic [2:0] flush_cnt, flush_cnt_n;
  logic err_n, redir_acc, aligned;
  assign redir_acc = bru_output_vld & bru_flush & (state == RUN | state == FLUSH);
  assign aligned = bru_redir_pc[1:0] == 2'b00;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      pc_out <= RESET_PC;
      flush_cnt <= '0;
      misalign_err <= 1'b0;
    end else begin
      state <= state_n;
      pc_out <= pc_n;
      flush_cnt <= flush_cnt_n;
      misalign_err <= err_n;
    end
  end
  always_comb begin
    state_n = state;
    pc_n = pc_out;
    flush_cnt_n = flush_cnt;
    err_n = 1'b0;
    if (redir_acc && !aligned) begin
      state_n = HALT;
      err_n = 1'b1;
    end else if (redir_acc) begin
      state_n = FLUSH;
      pc_n = bru_redir_pc;
      flush_cnt_n = 3'(FLUSH_CYCLES);
    end else begin
      case (state)
        IDLE, HALT: if (start_pulse) begin
          state_n = RUN;
          pc_n = start_pc;
        end
        RUN: pc_n = stall ? pc_out : pc_out + PC_WIDTH'(4);
        FLUSH: begin
          flush_cnt_n = flush_cnt - 3'd1;
          state_n = flush_cnt == 3'd1 ? RUN : FLUSH;
        end
        default: state_n = IDLE;
      endcase
    end
  end
  always_comb begin
    pc_vld = state == RUN;
    front_flush = redir_acc | state == FLUSH;
    core_busy = state == RUN | state == FLUSH;
  end
`ifdef PC_CTRL_PERF_EN
  logic [31:0] rcnt;
  always_ff @(posedge clk) begin
    if (rst) rcnt <= '0;
    else if (redir_acc && aligned && rcnt != 32'hFFFF_FFFF) rcnt <= rcnt + 32'd1;
  end
  assign redirect_cnt = rcnt;
`else
  assign redirect_cnt = '0;
`endif
endmodule

// File: tb/tb_u_pc_ctrl.sv
// tb_u_pc_ctrl: directed self-checking bench for u_pc_ctrl (FLUSH_CYCLES=2)
module tb_u_pc_ctrl;
  logic clk = 0, rst = 1, start_pulse = 0, stall = 0, bru_output_vld = 0, bru_flush = 0;
  logic [31:0] start_pc = '0, bru_redir_pc = '0;
  logic [31:0] pc_out, redirect_cnt;
  logic pc_vld, front_flush, misalign_err, core_busy;
  int vectors = 0, fails = 0;
`ifdef PC_CTRL_PERF_EN
  localparam logic [31:0] CNT3 = 32'd3;
`else
  localparam logic [31:0] CNT3 = 32'd0;
`endif
  u_pc_ctrl dut (
    .clk(clk), .rst(rst), .start_pulse(start_pulse), .start_pc(start_pc), .stall(stall),
    .bru_output_vld(bru_output_vld), .bru_flush(bru_flush), .bru_redir_pc(bru_redir_pc),
    .pc_out(pc_out), .pc_vld(pc_vld), .front_flush(front_flush), .misalign_err(misalign_err),
    .core_busy(core_busy), .redirect_cnt(redirect_cnt)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic chk_run(input string tag, input logic [31:0] pc);
    chk({tag, "_pc"}, pc_out, pc);
    chk({tag, "_vld"}, 32'(pc_vld), 32'd1);
    chk({tag, "_ff"}, 32'(front_flush), 32'd0);
  endtask
  task automatic chk_bubble(input string tag, input logic [31:0] pc);
    chk({tag, "_pc"}, pc_out, pc);
    chk({tag, "_vld"}, 32'(pc_vld), 32'd0);
    chk({tag, "_ff"}, 32'(front_flush), 32'd1);
  endtask
  task automatic redir(input logic [31:0] target);
    bru_output_vld = 1; bru_flush = 1; bru_redir_pc = target;
    #1;
  endtask
  task automatic chk_reset(input string tag);
    chk({tag, "_pc"}, pc_out, 32'h0);
    chk({tag, "_vld"}, 32'(pc_vld), 32'd0);
    chk({tag, "_ff"}, 32'(front_flush), 32'd0);
    chk({tag, "_err"}, 32'(misalign_err), 32'd0);
    chk({tag, "_busy"}, 32'(core_busy), 32'd0);
    chk({tag, "_cnt"}, redirect_cnt, 32'd0);
  endtask
  initial begin
    step(); step();
    rst = 0;
    chk_reset("reset");
    step();
    chk("idle_pc", pc_out, 32'h0);
    chk("idle_vld", 32'(pc_vld), 32'd0);
    start_pulse = 1; start_pc = 32'h1000;
    step();
    start_pulse = 0;
    chk_run("boot0", 32'h1000);
    chk("boot_busy", 32'(core_busy), 32'd1);
    step(); chk_run("boot1", 32'h1004);
    step(); chk_run("boot2", 32'h1008);
    stall = 1;
    step(); chk_run("stall1", 32'h1008);
    step(); chk_run("stall2", 32'h1008);
    stall = 0;
    step(); chk_run("inc3", 32'h100C);
    step(); chk_run("inc4", 32'h1010);
    redir(32'h0001_0000);
    chk("acc_ff", 32'(front_flush), 32'd1);
    step();
    bru_output_vld = 0; bru_flush = 0;
    chk_bubble("fl1", 32'h0001_0000);
    step(); chk_bubble("fl2", 32'h0001_0000);
    step(); chk_run("resume", 32'h0001_0000);
    step(); chk_run("resume_inc", 32'h0001_0004);
    bru_flush = 1; bru_redir_pc = 32'h5000;
    #1;
    chk("novld_ff", 32'(front_flush), 32'd0);
    step();
    bru_flush = 0;
    chk_run("novld", 32'h0001_0008);
    stall = 1;
    redir(32'h2000);
    chk("stall_acc_ff", 32'(front_flush), 32'd1);
    step();
    stall = 0;
    chk_bubble("b2b_a", 32'h2000);
    redir(32'h3000);
    step();
    bru_output_vld = 0; bru_flush = 0;
    chk_bubble("b2b_b", 32'h3000);
    step(); chk_bubble("b2b_c", 32'h3000);
    step(); chk_run("b2b_resume", 32'h3000);
    step(); chk_run("b2b_inc", 32'h3004);
    redir(32'h0000_BEF2);
    chk("mis_pre_err", 32'(misalign_err), 32'd0);
    step();
    bru_output_vld = 0; bru_flush = 0;
    chk("mis_err", 32'(misalign_err), 32'd1);
    chk("mis_vld", 32'(pc_vld), 32'd0);
    chk("mis_pc", pc_out, 32'h3004);
    chk("mis_busy", 32'(core_busy), 32'd0);
    chk("mis_cnt", redirect_cnt, CNT3);
    step();
    chk("halt_err", 32'(misalign_err), 32'd0);
    chk("halt_vld", 32'(pc_vld), 32'd0);
    chk("halt_pc", pc_out, 32'h3004);
    stall = 1; redir(32'h7000);
    chk("halt_ignore_ff", 32'(front_flush), 32'd0);
    step();
    stall = 0; bru_output_vld = 0; bru_flush = 0;
    chk("halt_hold_vld", 32'(pc_vld), 32'd0);
    start_pulse = 1; start_pc = 32'h40;
    step();
    start_pulse = 0;
    chk_run("restart", 32'h40);
    step(); chk_run("restart_inc", 32'h44);
    start_pulse = 1; start_pc = 32'hFFFF_FFF8;
    step();
    start_pulse = 0;
    chk_run("start_in_run", 32'h48);
    rst = 1;
    step();
    rst = 0;
    chk_reset("rst_run");
    start_pulse = 1; start_pc = 32'hFFFF_FFF8;
    step();
    start_pulse = 0;
    chk_run("wrap0", 32'hFFFF_FFF8);
    step(); chk_run("wrap1", 32'hFFFF_FFFC);
    step(); chk_run("wrap2", 32'h0);
    redir(32'h500);
    step();
    bru_output_vld = 0; bru_flush = 0;
    chk_bubble("pre_rst", 32'h500);
    rst = 1; start_pulse = 1; redir(32'h600);
    step();
    rst = 0; start_pulse = 0; bru_output_vld = 0; bru_flush = 0;
    #1;
    chk_reset("rst_flush");
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end
endmodule
